// File: rtl/sram_like_pkg.sv
// Shared encodings for the sram-like bus arbiter: FSM states, size codes, owner codes.
package sram_like_pkg;

   localparam int unsigned SIZE_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_DATA = 2'b10
   } state_t;

   typedef enum logic [SIZE_W-1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_t;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_t;

endpackage

// File: rtl/arb_pick2.sv
// Two-requester picker: bit 0 = inst, bit 1 = data; output is the owner code.
module arb_pick2
   import sram_like_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       rr_mode,
   output logic       grant
);

   // Lone requester wins; on a tie, data wins unless round-robin hands it to the one not served last.
   always_comb begin
      grant = 1'(OWN_DATA);
      if (req == 2'b01) begin
         grant = 1'(OWN_INST);
      end else if (req == 2'b11 && rr_mode) begin
         grant = ~last;
      end
   end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like slave port between the inst-side and data-side masters,
// one transaction outstanding at a time, address phase then data phase.
module sram_like_arbiter
   import sram_like_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RR_MODE = 0
) (
   input  logic              clk,
   input  logic              areset,

   input  logic              inst_req,
   input  logic              inst_wr,
   input  logic [1:0]        inst_size,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [DATA_W-1:0] inst_wdata,
   output logic [DATA_W-1:0] inst_rdata,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,

   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,

   output logic              s_req,
   output logic              s_wr,
   output logic [1:0]        s_size,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic              s_addr_ok,
   input  logic              s_data_ok
);

   state_t            state;
   state_t            state_nx;
   logic              owner;
   logic              last;
   logic              grant;
   logic              any_req;
   logic              owner_req;
   logic              owner_wr;
   logic [1:0]        owner_size;
   logic [ADDR_W-1:0] owner_addr;
   logic [DATA_W-1:0] owner_wdata;
   logic              addr_ok_c;
   logic              data_ok_c;

   assign any_req     = inst_req | data_req;
   assign owner_req   = (owner == OWN_DATA) ? data_req   : inst_req;
   assign owner_wr    = (owner == OWN_DATA) ? data_wr    : inst_wr;
   assign owner_size  = (owner == OWN_DATA) ? data_size  : inst_size;
   assign owner_addr  = (owner == OWN_DATA) ? data_addr  : inst_addr;
   assign owner_wdata = (owner == OWN_DATA) ? data_wdata : inst_wdata;

   // Read data is broadcast; only the owner's data_ok makes it meaningful.
   assign inst_rdata = s_rdata;
   assign data_rdata = s_rdata;

   arb_pick2 u_pick (
      .req     ({data_req, inst_req}),
      .last    (last),
      .rr_mode (1'(RR_MODE)),
      .grant   (grant)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Owner is latched at grant; last records who finished most recently.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         owner <= 1'(OWN_DATA);
         last  <= 1'(OWN_INST);
      end else begin
         if (state == ST_IDLE && any_req) begin
            owner <= grant;
         end
         if (data_ok_c) begin
            last <= owner;
         end
      end
   end

   // Next-state: an owner dropping its request in ADDR aborts without acks.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (any_req) state_nx = ST_ADDR;
         end
         ST_ADDR: begin
            if (!owner_req) begin
               state_nx = ST_IDLE;
            end else if (s_addr_ok && s_data_ok) begin
               state_nx = ST_IDLE;
            end else if (s_addr_ok) begin
               state_nx = ST_DATA;
            end
         end
         ST_DATA: begin
            if (s_data_ok) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Outputs: forward the owner's request to the slave and route slave acks back to it only.
   always_comb begin
      s_req     = 1'b0;
      s_wr      = 1'b0;
      s_size    = 2'b00;
      s_addr    = '0;
      s_wdata   = '0;
      addr_ok_c = 1'b0;
      data_ok_c = 1'b0;
      case (state)
         ST_ADDR: begin
            s_req     = owner_req;
            s_wr      = owner_wr;
            s_size    = owner_size;
            s_addr    = owner_addr;
            s_wdata   = owner_wdata;
            addr_ok_c = owner_req & s_addr_ok;
            data_ok_c = owner_req & s_addr_ok & s_data_ok;
         end
         ST_DATA: begin
            s_wr      = owner_wr;
            s_size    = owner_size;
            s_addr    = owner_addr;
            s_wdata   = owner_wdata;
            data_ok_c = s_data_ok;
         end
         default: ;
      endcase
      inst_addr_ok = addr_ok_c & (owner == OWN_INST);
      inst_data_ok = data_ok_c & (owner == OWN_INST);
      data_addr_ok = addr_ok_c & (owner == OWN_DATA);
      data_data_ok = data_ok_c & (owner == OWN_DATA);
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: instance 0 runs fixed priority, instance 1 round-robin.
module tb_sram_like_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        areset       [2];
   logic        inst_req     [2];
   logic        inst_wr      [2];
   logic [1:0]  inst_size    [2];
   logic [31:0] inst_addr    [2];
   logic [31:0] inst_wdata   [2];
   logic [31:0] inst_rdata   [2];
   logic        inst_addr_ok [2];
   logic        inst_data_ok [2];
   logic        data_req     [2];
   logic        data_wr      [2];
   logic [1:0]  data_size    [2];
   logic [31:0] data_addr    [2];
   logic [31:0] data_wdata   [2];
   logic [31:0] data_rdata   [2];
   logic        data_addr_ok [2];
   logic        data_data_ok [2];
   logic        s_req        [2];
   logic        s_wr         [2];
   logic [1:0]  s_size       [2];
   logic [31:0] s_addr       [2];
   logic [31:0] s_wdata      [2];
   logic [31:0] s_rdata      [2];
   logic        s_addr_ok    [2];
   logic        s_data_ok    [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      sram_like_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_MODE(g)) u_dut (
         .clk          (clk),
         .areset       (areset[g]),
         .inst_req     (inst_req[g]),
         .inst_wr      (inst_wr[g]),
         .inst_size    (inst_size[g]),
         .inst_addr    (inst_addr[g]),
         .inst_wdata   (inst_wdata[g]),
         .inst_rdata   (inst_rdata[g]),
         .inst_addr_ok (inst_addr_ok[g]),
         .inst_data_ok (inst_data_ok[g]),
         .data_req     (data_req[g]),
         .data_wr      (data_wr[g]),
         .data_size    (data_size[g]),
         .data_addr    (data_addr[g]),
         .data_wdata   (data_wdata[g]),
         .data_rdata   (data_rdata[g]),
         .data_addr_ok (data_addr_ok[g]),
         .data_data_ok (data_data_ok[g]),
         .s_req        (s_req[g]),
         .s_wr         (s_wr[g]),
         .s_size       (s_size[g]),
         .s_addr       (s_addr[g]),
         .s_wdata      (s_wdata[g]),
         .s_rdata      (s_rdata[g]),
         .s_addr_ok    (s_addr_ok[g]),
         .s_data_ok    (s_data_ok[g])
      );
   end

   int checks   = 0;
   int failures = 0;

   // Reference model: pending requests per master (0 inst, 1 data), last served, held payload.
   bit          pend  [2][2];
   int          last_m[2];
   logic [66:0] m_bus [2][2];

   function automatic int pick_model(input int d);
      if (pend[d][0] && pend[d][1]) return (d == 1) ? 1 - last_m[d] : 1;
      return pend[d][1] ? 1 : 0;
   endfunction

   // Expected {s_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}.
   function automatic logic [4:0] exp_vec(input logic sreq, input int own, input logic aok, input logic dok);
      logic [4:0] v;
      v = {sreq, 4'b0000};
      if (own == 0) begin
         v[3] = aok;
         v[2] = dok;
      end else begin
         v[1] = aok;
         v[0] = dok;
      end
      return v;
   endfunction

   task automatic clear_inputs(input int d);
      inst_req[d] = 0; inst_wr[d] = 0; inst_size[d] = 0; inst_addr[d] = 0; inst_wdata[d] = 0;
      data_req[d] = 0; data_wr[d] = 0; data_size[d] = 0; data_addr[d] = 0; data_wdata[d] = 0;
      s_rdata[d] = 0; s_addr_ok[d] = 0; s_data_ok[d] = 0;
   endtask

   task automatic raise(input int d, input int m, input logic [31:0] a, input logic w,
                        input logic [1:0] sz, input logic [31:0] wd);
      if (m == 0) begin
         inst_req[d] = 1; inst_wr[d] = w; inst_size[d] = sz; inst_addr[d] = a; inst_wdata[d] = wd;
      end else begin
         data_req[d] = 1; data_wr[d] = w; data_size[d] = sz; data_addr[d] = a; data_wdata[d] = wd;
      end
      pend[d][m]  = 1;
      m_bus[d][m] = {w, sz, a, wd};
   endtask

   task automatic raise_rand(input int d, input int m);
      raise(d, m, $urandom | 32'h1, 1'($urandom), 2'($urandom_range(2)), $urandom);
   endtask

   // One complete transaction, starting from the IDLE cycle in which requests are visible.
   task automatic run_txn(input int d, input int aw, input int dw, input bit same,
                          input logic [31:0] rd, output int got);
      int          own;
      logic [4:0]  ev;
      logic [4:0]  ov;
      logic [66:0] eb;
      own = pick_model(d);
      eb  = m_bus[d][own];
      got = -1;
      @(negedge clk); #1;
      ov = {s_req[d], inst_addr_ok[d], inst_data_ok[d], data_addr_ok[d], data_data_ok[d]};
      checks++;
      if (ov !== 5'b0 || {s_wr[d], s_size[d], s_addr[d], s_wdata[d]} !== 67'b0) begin
         failures++;
         $display("FAIL idle_grant dut%0d: acks=%b bus=%h, want 00000 / 0", d, ov,
                  {s_wr[d], s_size[d], s_addr[d], s_wdata[d]});
      end
      for (int i = 0; i < aw; i++) begin
         @(negedge clk); #1;
         ev = exp_vec(1'b1, own, 1'b0, 1'b0);
         ov = {s_req[d], inst_addr_ok[d], inst_data_ok[d], data_addr_ok[d], data_data_ok[d]};
         checks++;
         if (ov !== ev || {s_wr[d], s_size[d], s_addr[d], s_wdata[d]} !== eb) begin
            failures++;
            $display("FAIL addr_wait dut%0d: acks=%b bus=%h, want %b / %h", d, ov,
                     {s_wr[d], s_size[d], s_addr[d], s_wdata[d]}, ev, eb);
         end
      end
      @(negedge clk);
      s_addr_ok[d] = 1'b1;
      s_data_ok[d] = same;
      s_rdata[d]   = rd;
      #1;
      ev = exp_vec(1'b1, own, 1'b1, same);
      ov = {s_req[d], inst_addr_ok[d], inst_data_ok[d], data_addr_ok[d], data_data_ok[d]};
      got = inst_addr_ok[d] ? 0 : (data_addr_ok[d] ? 1 : -1);
      checks++;
      if (ov !== ev || {s_wr[d], s_size[d], s_addr[d], s_wdata[d]} !== eb) begin
         failures++;
         $display("FAIL addr_ok dut%0d: acks=%b bus=%h, want %b / %h", d, ov,
                  {s_wr[d], s_size[d], s_addr[d], s_wdata[d]}, ev, eb);
      end
      if (same) begin
         checks++;
         if (inst_rdata[d] !== rd || data_rdata[d] !== rd) begin
            failures++;
            $display("FAIL rdata_same dut%0d: inst=%h data=%h, want %h", d, inst_rdata[d], data_rdata[d], rd);
         end
      end
      @(posedge clk); #1;
      s_addr_ok[d] = 1'b0;
      s_data_ok[d] = 1'b0;
      if (own == 0) inst_req[d] = 1'b0;
      else          data_req[d] = 1'b0;
      pend[d][own] = 0;
      if (!same) begin
         for (int i = 0; i < dw; i++) begin
            @(negedge clk); #1;
            ev = exp_vec(1'b0, own, 1'b0, 1'b0);
            ov = {s_req[d], inst_addr_ok[d], inst_data_ok[d], data_addr_ok[d], data_data_ok[d]};
            checks++;
            if (ov !== ev || {s_wr[d], s_size[d], s_addr[d], s_wdata[d]} !== eb) begin
               failures++;
               $display("FAIL data_wait dut%0d: acks=%b bus=%h, want %b / %h", d, ov,
                        {s_wr[d], s_size[d], s_addr[d], s_wdata[d]}, ev, eb);
            end
         end
         @(negedge clk);
         s_data_ok[d] = 1'b1;
         s_rdata[d]   = rd;
         #1;
         ev = exp_vec(1'b0, own, 1'b0, 1'b1);
         ov = {s_req[d], inst_addr_ok[d], inst_data_ok[d], data_addr_ok[d], data_data_ok[d]};
         checks++;
         if (ov !== ev || inst_rdata[d] !== rd || data_rdata[d] !== rd) begin
            failures++;
            $display("FAIL data_ok dut%0d: acks=%b rdata=%h/%h, want %b / %h", d, ov,
                     inst_rdata[d], data_rdata[d], ev, rd);
         end
         @(posedge clk); #1;
         s_data_ok[d] = 1'b0;
      end
      last_m[d] = own;
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         areset[d]    = 1'b1;
         inst_req[d]  = 1'($urandom); inst_wr[d] = 1'($urandom); inst_size[d] = 2'($urandom);
         inst_addr[d] = $urandom;     inst_wdata[d] = $urandom;
         data_req[d]  = 1'($urandom); data_wr[d] = 1'($urandom); data_size[d] = 2'($urandom);
         data_addr[d] = $urandom;     data_wdata[d] = $urandom;
         s_rdata[d]   = $urandom;     s_addr_ok[d] = 1'($urandom); s_data_ok[d] = 1'($urandom);
      end
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({s_req[d], inst_addr_ok[d], inst_data_ok[d], data_addr_ok[d], data_data_ok[d]} !== 5'b0 ||
             {s_wr[d], s_size[d], s_addr[d], s_wdata[d]} !== 67'b0 ||
             inst_rdata[d] !== s_rdata[d] || data_rdata[d] !== s_rdata[d]) begin
            failures++;
            $display("FAIL reset dut%0d: s_req=%b acks=%b%b%b%b s_addr=%h rdata=%h, want all 0, rdata=%h",
                     d, s_req[d], inst_addr_ok[d], inst_data_ok[d], data_addr_ok[d], data_data_ok[d],
                     s_addr[d], inst_rdata[d], s_rdata[d]);
         end
         clear_inputs(d);
         pend[d][0] = 0;
         pend[d][1] = 0;
         last_m[d]  = 0;
      end
      @(negedge clk);
      areset[0] = 1'b0;
      areset[1] = 1'b0;
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (s_req[d] !== 1'b0 || s_addr[d] !== 32'h0) begin
            failures++;
            $display("FAIL post_reset dut%0d: s_req=%b s_addr=%h, want 0 / 0", d, s_req[d], s_addr[d]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_read();
      int got;
      raise(0, 0, 32'hBFC00000, 1'b0, 2'b10, 32'h0);
      run_txn(0, 0, 1, 1'b0, 32'h3C08BFAF, got);
      checks++;
      if (got !== 0) begin
         failures++;
         $display("FAIL single_read_owner: got %0d, want 0 (inst)", got);
      end
   endtask

   task automatic test_tie_fixed();
      int got;
      raise_rand(0, 0);
      raise_rand(0, 1);
      run_txn(0, $urandom_range(2), $urandom_range(2), 1'b0, $urandom, got);
      checks++;
      if (got !== 1) begin
         failures++;
         $display("FAIL tie_fixed_first: got %0d, want 1 (data)", got);
      end
      run_txn(0, 0, $urandom_range(2), 1'b0, $urandom, got);
      checks++;
      if (got !== 0) begin
         failures++;
         $display("FAIL tie_fixed_second: got %0d, want 0 (inst)", got);
      end
   endtask

   task automatic test_tie_rr();
      int got;
      int order[4] = '{1, 0, 1, 0};
      for (int k = 0; k < 4; k++) begin
         for (int m = 0; m < 2; m++) begin
            if (!pend[1][m] && k < 3) raise_rand(1, m);
         end
         run_txn(1, $urandom_range(1), $urandom_range(2), 1'b0, $urandom, got);
         checks++;
         if (got !== order[k]) begin
            failures++;
            $display("FAIL tie_rr_grant%0d: got %0d, want %0d", k, got, order[k]);
         end
      end
   endtask

   task automatic test_same_cycle();
      int got;
      raise_rand(0, 1);
      run_txn(0, 1, 0, 1'b1, $urandom, got);
      checks++;
      if (got !== 1) begin
         failures++;
         $display("FAIL same_cycle_owner: got %0d, want 1", got);
      end
      @(negedge clk); #1;
      checks++;
      if (s_req[0] !== 1'b0 || s_addr[0] !== 32'h0 || data_data_ok[0] !== 1'b0) begin
         failures++;
         $display("FAIL same_cycle_idle: s_req=%b s_addr=%h dok=%b, want 0/0/0", s_req[0], s_addr[0], data_data_ok[0]);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_abort();
      raise_rand(0, 0);
      @(negedge clk); #1;
      @(negedge clk); #1;
      checks++;
      if (s_req[0] !== 1'b1 || {s_wr[0], s_size[0], s_addr[0], s_wdata[0]} !== m_bus[0][0]) begin
         failures++;
         $display("FAIL abort_addr: s_req=%b s_addr=%h, want 1 / %h", s_req[0], s_addr[0], m_bus[0][0][63:32]);
      end
      @(negedge clk);
      inst_req[0] = 1'b0;
      pend[0][0]  = 0;
      #1;
      checks++;
      if ({s_req[0], inst_addr_ok[0], inst_data_ok[0], data_addr_ok[0], data_data_ok[0]} !== 5'b0) begin
         failures++;
         $display("FAIL abort_drop: s_req=%b iaok=%b, want 0/0", s_req[0], inst_addr_ok[0]);
      end
      @(negedge clk); #1;
      checks++;
      if (s_req[0] !== 1'b0 || s_addr[0] !== 32'h0) begin
         failures++;
         $display("FAIL abort_idle: s_req=%b s_addr=%h, want 0 / 0", s_req[0], s_addr[0]);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      raise_rand(1, 0);
      @(negedge clk); #1;
      @(negedge clk);
      s_addr_ok[1] = 1'b1;
      #1;
      @(posedge clk); #1;
      s_addr_ok[1] = 1'b0;
      inst_req[1]  = 1'b0;
      pend[1][0]   = 0;
      @(negedge clk); #1;
      checks++;
      if (s_req[1] !== 1'b0 || {s_wr[1], s_size[1], s_addr[1], s_wdata[1]} !== m_bus[1][0]) begin
         failures++;
         $display("FAIL mid_in_data: s_req=%b s_addr=%h, want 0 / %h", s_req[1], s_addr[1], m_bus[1][0][63:32]);
      end
      areset[1] = 1'b1;
      #1;
      checks++;
      if (s_req[1] !== 1'b0 || {s_wr[1], s_size[1], s_addr[1], s_wdata[1]} !== 67'b0) begin
         failures++;
         $display("FAIL mid_reset_idle: s_addr=%h, want 0", s_addr[1]);
      end
      last_m[1] = 0;
      @(negedge clk);
      areset[1]    = 1'b0;
      s_data_ok[1] = 1'b1;
      s_rdata[1]   = $urandom;
      #1;
      checks++;
      if ({s_req[1], inst_addr_ok[1], inst_data_ok[1], data_addr_ok[1], data_data_ok[1]} !== 5'b0) begin
         failures++;
         $display("FAIL mid_spurious_dok: idok=%b ddok=%b, want 0/0", inst_data_ok[1], data_data_ok[1]);
      end
      @(posedge clk); #1;
      s_data_ok[1] = 1'b0;
   endtask

   task automatic test_random();
      int got;
      int own;
      for (int d = 0; d < 2; d++) begin
         for (int it = 0; it < 30; it++) begin
            for (int m = 0; m < 2; m++) begin
               if (!pend[d][m] && $urandom_range(1) == 1) raise_rand(d, m);
            end
            if (!pend[d][0] && !pend[d][1]) raise_rand(d, $urandom_range(1));
            own = pick_model(d);
            run_txn(d, $urandom_range(3), $urandom_range(3), ($urandom_range(3) == 0), $urandom, got);
            checks++;
            if (got !== own) begin
               failures++;
               $display("FAIL random_owner dut%0d it%0d: got %0d, want %0d", d, it, got, own);
            end
         end
         while (pend[d][0] || pend[d][1]) begin
            own = pick_model(d);
            run_txn(d, $urandom_range(2), $urandom_range(2), 1'b0, $urandom, got);
            checks++;
            if (got !== own) begin
               failures++;
               $display("FAIL random_drain dut%0d: got %0d, want %0d", d, got, own);
            end
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         areset[d] = 1'b1;
         clear_inputs(d);
      end
      test_reset();
      test_single_read();
      test_tie_fixed();
      test_tie_rr();
      test_same_cycle();
      test_abort();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: run exceeded time bound");
      $fatal(1);
   end

endmodule
